// File: rtl/sub_bytes_engine.sv
// Time-multiplexed AES SubBytes: LANES S-box lookups per cycle, NBYTES/LANES beats per state.
// Define INV_SBOX_EN to add the inverse tables and honour in_inv (InvSubBytes).
module sub_bytes_engine #(
    parameter int unsigned NBYTES = 16,
    parameter int unsigned LANES  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_inv,
    input  logic [8*NBYTES-1:0] prevState,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] nextState,
    output logic                busy
);

    localparam int unsigned BEATS = NBYTES / LANES;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2047:0] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at bits 2047-8x downto 2040-8x; {~x,3'b111} is that top bit index.
    function automatic logic [7:0] fwdLookup(input logic [7:0] x);
        return FWD_SBOX[{~x, 3'b111} -: 8];
    endfunction

`ifdef INV_SBOX_EN
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] invLookup(input logic [7:0] x);
        return INV_SBOX[{~x, 3'b111} -: 8];
    endfunction
`endif

    logic [1:0]                        state;
    logic [CW-1:0]                     beat;
    logic [CW-1:0]                     rowSel;
    logic                              inv;
    logic                              accept;
    logic [BEATS-1:0][LANES-1:0][7:0]  work;
    logic [BEATS-1:0][LANES-1:0][7:0]  workNext;
    logic [LANES-1:0][7:0]             rowIn;
    logic [LANES-1:0][7:0]             rowOut;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign nextState = work;

    // Byte 0 is the MSB, so beat 0 works on the topmost row of the work grid.
    assign rowSel = LAST_BEAT - beat;
    assign rowIn  = work[rowSel];

    for (genvar l = 0; l < LANES; l++) begin : gLane
`ifdef INV_SBOX_EN
        assign rowOut[l] = inv ? invLookup(rowIn[l]) : fwdLookup(rowIn[l]);
`else
        assign rowOut[l] = fwdLookup(rowIn[l]);
`endif
    end

    always_comb begin
        workNext         = work;
        workNext[rowSel] = rowOut;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            beat  <= '0;
            work  <= '0;
        end else if (accept) begin
            work  <= prevState;
            beat  <= '0;
            state <= BUSY;
        end else begin
            case (state)
                BUSY: begin
                    work <= workNext;
                    if (beat == LAST_BEAT) begin
                        beat  <= '0;
                        state <= DONE;
                    end else begin
                        beat <= beat + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                IDLE: ;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INV_SBOX_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv <= 1'b0;
        end else if (accept) begin
            inv <= in_inv;
        end
    end
`else
    logic unusedInv;
    assign inv       = 1'b0;
    assign unusedInv = in_inv ^ inv;
`endif

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed checks for sub_bytes_engine plus a LANES sweep against a GF(2^8) arithmetic S-box model.
// Build with +define+INV_SBOX_EN to check the inverse path; otherwise the forward result is expected.
module tb_sub_bytes_engine;

    logic         clk;
    logic         reset;
    logic         inValid;
    logic         inReady;
    logic         inInv;
    logic [127:0] prevState;
    logic         outValid;
    logic         outReady;
    logic [127:0] nextState;
    logic         busy;

    logic         swInValid;
    logic [127:0] swPrev;
    logic [4:0]   swReady;
    logic [4:0]   swValid;
    logic [4:0]   swBusy;
    logic [127:0] swNext [5];

    int checkCount;
    int passCount;

    logic [7:0] modelSbox [256];
    logic [7:0] modelInv  [256];

    sub_bytes_engine #(.NBYTES(16), .LANES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_inv    (inInv),
        .prevState (prevState),
        .out_valid (outValid),
        .out_ready (outReady),
        .nextState (nextState),
        .busy      (busy)
    );

    for (genvar g = 0; g < 5; g++) begin : gSweep
        sub_bytes_engine #(.NBYTES(16), .LANES(1 << g)) uSweep (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (swInValid),
            .in_ready  (swReady[g]),
            .in_inv    (1'b0),
            .prevState (swPrev),
            .out_valid (swValid[g]),
            .out_ready (1'b1),
            .nextState (swNext[g]),
            .busy      (swBusy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Steps until out_valid, returning edges taken and whether in_ready was seen while waiting.
    task automatic waitDone(output int n, output logic sawReady);
        n = 0;
        sawReady = 1'b0;
        do begin
            step();
            n++;
            if (!outValid) sawReady |= inReady;
        end while (!outValid && n < 40);
        if (!outValid) checkEq("doneTimeout", 128'd0, 128'd1);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = '0;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] modelSub(input logic [127:0] s, input logic useInv);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            b = s[127-8*i -: 8];
            r[127-8*i -: 8] = useInv ? modelInv[b] : modelSbox[b];
        end
        return r;
    endfunction

    initial begin
        int           n;
        int           swLat [5];
        logic [127:0] swRes [5];
        logic         sawReady;
        logic         stable;
        logic [7:0]   b;
        logic [7:0]   r;
        logic [127:0] expInv;
        logic [127:0] stateA;
        logic [127:0] stateB;

        checkCount = 0;
        passCount  = 0;
        for (int x = 0; x < 256; x++) begin
            b = 8'(x);
            r = 8'h01;
            for (int k = 0; k < 254; k++) r = gmul(r, b);
            r = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
            modelSbox[x] = r;
            modelInv[r]  = b;
        end

        stateA = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        stateB = 128'h00112233445566778899aabbccddeeff;

        reset = 1'b1; inValid = 1'b0; inInv = 1'b0; prevState = '0; outReady = 1'b0;
        swInValid = 1'b0; swPrev = '0;
        step(); step();
        reset = 1'b0;
        checkEq("rstReady", inReady, 1'b1);
        checkEq("rstValid", outValid, 1'b0);
        checkEq("rstBusy", busy, 1'b0);
        checkEq("rstNext", nextState, 128'd0);

        // FIPS-197 round-1 vector, result held while out_ready=0
        inValid = 1'b1; prevState = stateA;
        step();
        inValid = 1'b0;
        checkEq("t1Busy", busy, 1'b1);
        waitDone(n, sawReady);
        checkEq("t1Latency", n, 4);
        checkEq("t1Result", nextState, 128'hd42711aee0bf98f1b8b45de51e415230);
        outReady = 1'b1;
        step();
        checkEq("t1Idle", outValid, 1'b0);

        // back-to-back all-00 then all-FF with in_valid held high
        inValid = 1'b1; prevState = '0;
        step();
        waitDone(n, sawReady);
        checkEq("t2aNoReady", sawReady, 1'b0);
        checkEq("t2aLatency", n, 4);
        checkEq("t2aResult", nextState, {16{8'h63}});
        checkEq("t2aReadyInDone", inReady, 1'b1);
        prevState = '1;
        step();
        checkEq("t2bBusy", busy, 1'b1);
        checkEq("t2bValidLow", outValid, 1'b0);
        waitDone(n, sawReady);
        inValid = 1'b0;
        checkEq("t2bNoReady", sawReady, 1'b0);
        checkEq("t2bLatency", n, 4);
        checkEq("t2bResult", nextState, {16{8'h16}});
        step();

        // backpressure in DONE with a competing request
        outReady = 1'b0; inValid = 1'b1; prevState = stateA;
        step();
        inValid = 1'b0;
        waitDone(n, sawReady);
        inValid = 1'b1; prevState = stateB;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (!outValid || inReady || busy || nextState !== 128'hd42711aee0bf98f1b8b45de51e415230)
                stable = 1'b0;
        end
        checkEq("t3Stable", stable, 1'b1);
        outReady = 1'b1;
        #1;
        checkEq("t3ReadyRelease", inReady, 1'b1);
        step();
        inValid = 1'b0;
        waitDone(n, sawReady);
        checkEq("t3Latency", n, 4);
        checkEq("t3Result", nextState, 128'h638293c31bfc33f5c4eeacea4bc12816);
        step();

        // asynchronous reset while beat 2 is pending
        inValid = 1'b1; prevState = stateB;
        step();
        inValid = 1'b0;
        step(); step();
        reset = 1'b1;
        #1;
        checkEq("t4Valid", outValid, 1'b0);
        checkEq("t4Next", nextState, 128'd0);
        checkEq("t4Ready", inReady, 1'b1);
        checkEq("t4Busy", busy, 1'b0);
        step();
        reset = 1'b0;
        inValid = 1'b1; prevState = stateA;
        step();
        inValid = 1'b0;
        waitDone(n, sawReady);
        checkEq("t4Latency", n, 4);
        checkEq("t4Result", nextState, 128'hd42711aee0bf98f1b8b45de51e415230);
        step();

        // inverse request; in_inv flipped after accept must not matter
`ifdef INV_SBOX_EN
        expInv = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
`else
        expInv = modelSub(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0);
`endif
        inValid = 1'b1; inInv = 1'b1; prevState = 128'hd42711aee0bf98f1b8b45de51e415230;
        step();
        inValid = 1'b0; inInv = 1'b0;
        waitDone(n, sawReady);
        checkEq("t5Result", nextState, expInv);
        step();

        // LANES sweep on random states
        for (int t = 0; t < 3; t++) begin
            swPrev = {$urandom, $urandom, $urandom, $urandom};
            checkEq("swReady", swReady, 5'h1f);
            swInValid = 1'b1;
            step();
            swInValid = 1'b0;
            checkEq("swBusy", swBusy, 5'h1f);
            for (int g = 0; g < 5; g++) begin
                swLat[g] = 0;
                swRes[g] = '0;
            end
            for (int c = 1; c <= 20; c++) begin
                step();
                for (int g = 0; g < 5; g++) begin
                    if (swValid[g] && swLat[g] == 0) begin
                        swLat[g] = c;
                        swRes[g] = swNext[g];
                    end
                end
            end
            for (int g = 0; g < 5; g++) begin
                checkEq($sformatf("swLatency%0d", 1 << g), swLat[g], 16 >> g);
                checkEq($sformatf("swResult%0d", 1 << g), swRes[g], modelSub(swPrev, 1'b0));
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
